iter_ctrl_div_sqrt_mvp: RTL
===========================

Name: iter_ctrl_div_sqrt_mvp

Overview:
Multi-cycle sequencer for the radix-2 mantissa divide/square-root path. It accepts one normalized operand pair per operation and owns the partial-remainder, root and quotient registers. It retires one quotient/root bit per cycle for a run-time selected precision, then returns the right-aligned result plus a sticky bit. It sits between the div_sqrt_mvp preprocess stage (normalization, exponent parity) and the rounding/norm stage.

Parameters:
WIDTH, 24, operand mantissa width including hidden bit
MAX_ITER, 27, maximum result bits (mantissa + guard/round bits); sets Q width
PREC_W, 5, width of precision input; must satisfy 2^PREC_W > MAX_ITER

Ports:
Clk_CI  in  1  clock
Rst_RI  in  1  reset; synchronous, active-high
Start_SI  in  1  start request; accepted only when Ready_SO=1
Div_enable_SI  in  1  1 = divide, sampled with Start_SI
Sqrt_enable_SI  in  1  1 = square root, sampled with Start_SI
Kill_SI  in  1  abort current operation
Prec_DI  in  PREC_W  requested result bits P, sampled with Start_SI
A_DI  in  WIDTH  dividend / radicand, MSB set
B_DI  in  WIDTH  divisor, MSB set; ignored for sqrt
Ready_SO  out  1  idle, can accept start
Busy_SO  out  1  iterating
Done_SO  out  1  one-cycle result-valid pulse
Q_DO  out  MAX_ITER  result, right-aligned in P bits, upper bits zero
Sticky_DO  out  1  final remainder nonzero

Behaviour:
- Reset (sync, high): state IDLE; Ready_SO=1, Busy_SO=0, Done_SO=0, Q_DO=0, Sticky_DO=0; all internal registers cleared. Reset overrides Start_SI and Kill_SI in the same cycle and aborts any operation with no Done_SO.
- FSM: IDLE -> ITER on accepted start; ITER -> DONE after P iterations; DONE -> IDLE after 1 cycle. Kill_SI in ITER or DONE -> IDLE next cycle with no Done_SO; Q_DO/Sticky_DO keep their previous values.
- Start accepted iff state IDLE and Start_SI=1 and exactly one of Div_enable_SI/Sqrt_enable_SI=1. Both or neither set: request ignored, stay IDLE. Start_SI outside IDLE: ignored, no queuing.
- Precision clamp at acceptance: div P = min(max(Prec_DI,1),MAX_ITER); sqrt P = min(max(Prec_DI,ceil(WIDTH/2)),MAX_ITER).
- Divide result: Q = floor(A*2^(P-1)/B); Sticky = (A*2^(P-1) mod B) != 0. Normalized inputs give Q < 2^P.
- Sqrt result: Q = floor(sqrt(A*2^(2P-WIDTH))); Sticky = remainder != 0. Odd-exponent handling is upstream; A is used as given.
- Datapath: restoring, one bit per cycle, single (WIDTH+3)-bit subtractor shared by both modes. Division trial = 2R - B. Sqrt trial = 4R + next radicand pair - (4Q+1). Commit when non-negative. Q shifts left, inserting the committed bit.
- Latency: start accepted at edge t; ITER occupies cycles t+1..t+P; Done_SO=1 in cycle t+P+1 with Q_DO/Sticky_DO valid; Ready_SO=1 again in cycle t+P+2. Back-to-back throughput is one operation per P+2 cycles.
- Ready_SO=1 only in IDLE. Busy_SO=1 only in ITER. Q_DO/Sticky_DO update only on entry to DONE and hold until the next DONE or reset.
- Iteration counter counts down from P-1 and wraps to no value (exit at 0). With P=1, ITER lasts exactly one cycle.
- Mode and operand registers are captured at acceptance. Input changes during ITER have no effect.

Test Plan:
- Reset, then div A=0xC00000, B=0x800000, P=24, start at t -> Done_SO at t+25, Q_DO=0xC00000, Sticky_DO=0, Ready_SO at t+26.
- Div A=0x800000, B=0xC00000, P=24 -> Q_DO=0x555555, Sticky_DO=1. Repeat with P=27 -> Q_DO=0x2AAAAAA, Sticky_DO=1.
- Sqrt A=0x800000, P=24 -> Q_DO=0xB504F3, Sticky_DO=1. Sqrt A=0x900000, P=24 -> Q_DO=0xC00000, Sticky_DO=0. Sqrt with Prec_DI=3 -> clamped to 12, Done_SO at t+13.
- Start with Div_enable_SI=Sqrt_enable_SI=1, then with both 0 -> no state change, Ready_SO stays 1, no Done_SO. Start pulse during ITER -> ignored, first result unchanged.
- Kill_SI at t+5 of a P=24 divide -> IDLE at t+6, no Done_SO, Q_DO retains prior result. Next start completes normally.
- Rst_RI asserted mid-ITER together with Start_SI -> next cycle all outputs at reset values, no Done_SO. Div P=1, A=B=0x800000 -> Done_SO at t+2, Q_DO=1.

Source files
------------

// File: rtl/iter_ctrl_div_sqrt_mvp.sv
// Radix-2 restoring divide / square-root sequencer: one result bit per cycle
// for a run-time precision, returning a right-aligned quotient/root plus sticky.
module iter_ctrl_div_sqrt_mvp #(
  parameter int WIDTH    = 24,
  parameter int MAX_ITER = 27,
  parameter int PREC_W   = 5
) (
  input  logic                Clk_CI,
  input  logic                Rst_RI,
  input  logic                Start_SI,
  input  logic                Div_enable_SI,
  input  logic                Sqrt_enable_SI,
  input  logic                Kill_SI,
  input  logic [PREC_W-1:0]   Prec_DI,
  input  logic [WIDTH-1:0]    A_DI,
  input  logic [WIDTH-1:0]    B_DI,
  output logic                Ready_SO,
  output logic                Busy_SO,
  output logic                Done_SO,
  output logic [MAX_ITER-1:0] Q_DO,
  output logic                Sticky_DO,
  output logic [1:0]          State_SO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // The sqrt partial remainder grows to about two bits beyond the root, so the
  // shared subtractor is sized from the wider of the operand and result widths.
  localparam int SUB_W    = ((MAX_ITER > WIDTH) ? MAX_ITER : WIDTH) + 3;
  localparam int SQRT_MIN = (WIDTH + 1) / 2;

  state_t              state;
  logic                mode_div;
  logic [WIDTH-1:0]    b_reg;
  logic [WIDTH-1:0]    rad_reg;
  logic [SUB_W-1:0]    rem_reg;
  logic [MAX_ITER-1:0] q_reg;
  logic [PREC_W-1:0]   cnt_reg;

  logic                start_ok;
  logic [PREC_W-1:0]   p_min;
  logic [PREC_W-1:0]   p_sel;
  logic [1:0]          pair;
  logic [SUB_W-1:0]    op_a;
  logic [SUB_W-1:0]    op_b;
  logic [SUB_W:0]      diff;
  logic                commit;
  logic [SUB_W-1:0]    rem_next;
  logic [MAX_ITER-1:0] q_next;

  // Handshake: a request transfers on a rising edge where Start_SI=1 and
  // Ready_SO=1 with exactly one mode enable set; anything else is dropped.
  assign start_ok = (state == IDLE) && Start_SI && (Div_enable_SI ^ Sqrt_enable_SI);
  assign State_SO = state;

  always_comb begin
    p_min = Sqrt_enable_SI ? PREC_W'(SQRT_MIN) : PREC_W'(1);
    p_sel = (Prec_DI < p_min) ? p_min : Prec_DI;
    if (p_sel > PREC_W'(MAX_ITER)) begin
      p_sel = PREC_W'(MAX_ITER);
    end
  end

  // Divide keeps 2R in rem_reg (doubling folded into the update), so the
  // trial 2R - B is rem_reg - B; sqrt trial is 4R + pair - (4Q + 1).
  always_comb begin
    pair     = rad_reg[WIDTH-1 -: 2];
    op_a     = mode_div ? rem_reg : {rem_reg[SUB_W-3:0], pair};
    op_b     = mode_div ? SUB_W'(b_reg) : SUB_W'({q_reg, 2'b01});
    diff     = {1'b0, op_a} - {1'b0, op_b};
    commit   = ~diff[SUB_W];
    rem_next = commit ? diff[SUB_W-1:0] : op_a;
    q_next   = {q_reg[MAX_ITER-2:0], commit};
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state     <= IDLE;
      Ready_SO  <= 1'b1;
      Busy_SO   <= 1'b0;
      Done_SO   <= 1'b0;
      Q_DO      <= '0;
      Sticky_DO <= 1'b0;
      mode_div  <= 1'b0;
      b_reg     <= '0;
      rad_reg   <= '0;
      rem_reg   <= '0;
      q_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      Done_SO <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state    <= ITER;
            Ready_SO <= 1'b0;
            Busy_SO  <= 1'b1;
            mode_div <= Div_enable_SI;
            b_reg    <= B_DI;
            rad_reg  <= A_DI;
            rem_reg  <= Div_enable_SI ? SUB_W'(A_DI) : '0;
            q_reg    <= '0;
            cnt_reg  <= p_sel - PREC_W'(1);
          end
        end
        ITER: begin
          if (Kill_SI) begin
            state    <= IDLE;
            Busy_SO  <= 1'b0;
            Ready_SO <= 1'b1;
          end else begin
            q_reg   <= q_next;
            rad_reg <= {rad_reg[WIDTH-3:0], 2'b00};
            rem_reg <= mode_div ? {rem_next[SUB_W-2:0], 1'b0} : rem_next;
            if (cnt_reg == '0) begin
              state     <= DONE;
              Busy_SO   <= 1'b0;
              Done_SO   <= 1'b1;
              Q_DO      <= q_next;
              Sticky_DO <= |rem_next;
            end else begin
              cnt_reg <= cnt_reg - PREC_W'(1);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          Ready_SO <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          Ready_SO <= 1'b1;
          Busy_SO  <= 1'b0;
        end
      endcase
    end
  end

endmodule
